// File: rtl/i2s_codec_if.sv
// ---------------------------------------------------------------------------
// i2s_codec_if
//
// Purpose:
//   Codec-side link for the audio sample path. Divides clk down to the codec
//   bit clock, generates the frame clock, serialises the 16-bit mixed sample
//   onto the DAC line as standard I2S, and deserialises the left ADC slot
//   back into a 16-bit parallel sample.
//
// Parameters:
//   BCLK_HALF    clk cycles per BCLK half-period (2..255); BCLK = clk/(2*BCLK_HALF)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   audio_output sample to play, latched at frame start
//   audio_input  last captured left-channel ADC sample
//   sample_req   one-clk pulse, 2*BCLK_HALF clk before audio_output is latched
//   sample_end   one-clk pulse, audio_input has just been updated
//   aud_bclk     codec bit clock
//   aud_lrck     codec frame clock (0 = left slot, 1 = right slot)
//   aud_dacdat   serial DAC data
//   loopback     (only with I2S_LOOPBACK_EN) capture aud_dacdat instead of
//                aud_adcdat
//   aud_adcdat   serial ADC data, synchronous to aud_bclk
//
// Optional feature macro: I2S_LOOPBACK_EN
//
// Handshake: none. sample_req/sample_end are single-cycle strobes; the
// consumer must present audio_output from the sample_req cycle until the
// following BCLK fall event, and may read audio_input whenever sample_end
// is high (it then holds for the rest of the frame).
// ---------------------------------------------------------------------------
module i2s_codec_if #(
    parameter int BCLK_HALF = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] audio_output,
    output logic [15:0] audio_input,
    output logic        sample_req,
    output logic        sample_end,
    output logic        aud_bclk,
    output logic        aud_lrck,
    output logic        aud_dacdat,
`ifdef I2S_LOOPBACK_EN
    input  logic        loopback,
`endif
    input  logic        aud_adcdat
);

    localparam logic [7:0] DIV_MAX = 8'(BCLK_HALF - 1);

    logic [7:0]  div_cnt_q, div_cnt_d;
    logic        bclk_q, bclk_d;
    logic [5:0]  bit_cnt_q, bit_cnt_d;
    logic        lrck_q, lrck_d;
    logic        dacdat_q, dacdat_d;
    logic [15:0] hold_q, hold_d;
    // Only 15 bits are kept: the 16th captured bit is taken straight from the
    // input on the transfer cycle.
    logic [14:0] shift_q, shift_d;
    logic [15:0] ain_q, ain_d;
    logic        req_q, req_d;
    logic        end_q, end_d;

    logic        tick;
    logic        rise_ev;
    logic        fall_ev;
    logic        adc_bit;
    logic [4:0]  slot_pos;
    logic [3:0]  dac_idx;

`ifdef I2S_LOOPBACK_EN
    assign adc_bit = loopback ? dacdat_q : aud_adcdat;
`else
    assign adc_bit = aud_adcdat;
`endif

    always_comb begin
        tick      = (div_cnt_q == DIV_MAX);
        rise_ev   = tick & ~bclk_q;
        fall_ev   = tick & bclk_q;

        div_cnt_d = tick ? 8'd0 : div_cnt_q + 8'd1;
        bclk_d    = tick ? ~bclk_q : bclk_q;
        bit_cnt_d = bit_cnt_q;
        lrck_d    = lrck_q;
        dacdat_d  = dacdat_q;
        hold_d    = hold_q;
        shift_d   = shift_q;
        ain_d     = ain_q;
        req_d     = 1'b0;
        end_d     = 1'b0;
        slot_pos  = 5'd0;
        dac_idx   = 4'd0;

        if (fall_ev) begin
            bit_cnt_d = bit_cnt_q + 6'd1;
            lrck_d    = bit_cnt_d[5];
            slot_pos  = bit_cnt_d[4:0];
            dac_idx   = 4'(5'd16 - slot_pos);
            // Position 0 is the I2S one-bit delay; it uses the old hold value
            // path but always drives 0, so the load below cannot leak into it.
            if (slot_pos >= 5'd1 && slot_pos <= 5'd16) begin
                dacdat_d = hold_q[dac_idx];
            end else begin
                dacdat_d = 1'b0;
            end
            if (bit_cnt_d == 6'd0) begin
                hold_d = audio_output;
            end
            req_d = (bit_cnt_d == 6'd63);
        end

        if (rise_ev) begin
            if (bit_cnt_q >= 6'd1 && bit_cnt_q <= 6'd16) begin
                shift_d = {shift_q[13:0], adc_bit};
            end
            if (bit_cnt_q == 6'd16) begin
                ain_d = {shift_q, adc_bit};
                end_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= 8'd0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= 6'd0;
            lrck_q    <= 1'b0;
            dacdat_q  <= 1'b0;
            hold_q    <= 16'd0;
            shift_q   <= 15'd0;
            ain_q     <= 16'd0;
            req_q     <= 1'b0;
            end_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
            bit_cnt_q <= bit_cnt_d;
            lrck_q    <= lrck_d;
            dacdat_q  <= dacdat_d;
            hold_q    <= hold_d;
            shift_q   <= shift_d;
            ain_q     <= ain_d;
            req_q     <= req_d;
            end_q     <= end_d;
        end
    end

    assign audio_input = ain_q;
    assign sample_req  = req_q;
    assign sample_end  = end_q;
    assign aud_bclk    = bclk_q;
    assign aud_lrck    = lrck_q;
    assign aud_dacdat  = dacdat_q;

endmodule

// File: tb/tb_i2s_codec_if.sv
// ---------------------------------------------------------------------------
// tb_i2s_codec_if
//
// Directed bench for i2s_codec_if with BCLK_HALF = 8 (BCLK period 16 clk,
// frame 1024 clk). Time is counted in clk edges since reset release, so
// within a frame, edge r has bit_cnt = r/16 (mod 64), fall events at
// multiples of 16 and rise events at 16*m+8. Each table row describes one
// frame: the ADC word driven into the left slot, the word the DAC must
// serialise, the audio_input expected after capture, and the audio_output
// value presented on that frame's sample_req cycle.
// ---------------------------------------------------------------------------
module tb_i2s_codec_if;

    localparam int BCLK_HALF = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] audio_output = 16'd0;
    logic [15:0] audio_input;
    logic        sample_req;
    logic        sample_end;
    logic        aud_bclk;
    logic        aud_lrck;
    logic        aud_dacdat;
    logic        aud_adcdat = 1'b0;
`ifdef I2S_LOOPBACK_EN
    logic        loopback = 1'b0;
`endif

    always #5 clk = ~clk;

    i2s_codec_if #(.BCLK_HALF(BCLK_HALF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .audio_output (audio_output),
        .audio_input  (audio_input),
        .sample_req   (sample_req),
        .sample_end   (sample_end),
        .aud_bclk     (aud_bclk),
        .aud_lrck     (aud_lrck),
        .aud_dacdat   (aud_dacdat),
`ifdef I2S_LOOPBACK_EN
        .loopback     (loopback),
`endif
        .aud_adcdat   (aud_adcdat)
    );

    typedef struct {
        logic [15:0] aout;     // presented on this frame's sample_req cycle
        logic [15:0] adc;      // driven MSB-first into left positions 1..16
        logic [15:0] exp_dac;  // word the DAC must serialise in this frame
        logic [15:0] exp_ain;  // audio_input after this frame's capture
    } vec_t;

    vec_t        vecs [4];
    vec_t        vt;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] last_ain = 16'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected 64-position DAC line for one frame: word MSB-first in
    // positions 1..16 and again in 33..48, zero elsewhere.
    function automatic logic [63:0] dac_pattern(input logic [15:0] w);
        logic [63:0] p;
        p = 64'd0;
        for (int i = 1; i <= 16; i++) begin
            p[i]      = w[16 - i];
            p[32 + i] = w[16 - i];
        end
        return p;
    endfunction

    task automatic run_frame(input vec_t v);
        int          base;
        int          r;
        int          pos;
        int          sr_n;
        int          sr_at;
        int          se_n;
        int          se_at;
        int          lr_hi;
        logic [63:0] dac_seen;
        base     = cyc;
        sr_n     = 0;
        sr_at    = -1;
        se_n     = 0;
        se_at    = -1;
        lr_hi    = 0;
        dac_seen = 64'd0;
        for (int i = 0; i < 1024; i++) begin
            step();
            r   = cyc - base;
            pos = (r / 16) % 64;
            if (r == 7)  check("bclk_low_before_rise", 64'(aud_bclk), 64'd0);
            if (r == 8)  check("bclk_first_rise", 64'(aud_bclk), 64'd1);
            if (r == 16) check("bclk_fall", 64'(aud_bclk), 64'd0);
            if (r % 16 == 4) dac_seen[pos] = aud_dacdat;
            if (aud_lrck) lr_hi++;
            if (sample_req) begin
                sr_n++;
                sr_at = r;
            end
            if (sample_end) begin
                se_n++;
                se_at = r;
            end
            if (r == 200) check("ain_before_capture", 64'(audio_input), 64'(last_ain));
            if (r == 1008) audio_output = v.aout;
            // New ADC bit goes out just after each fall event.
            if (r % 16 == 0) begin
                if (pos >= 1 && pos <= 16) aud_adcdat = v.adc[16 - pos];
                else if (pos >= 32)        aud_adcdat = 1'b1;
                else                       aud_adcdat = 1'b0;
            end
        end
        check("dac_frame_bits", dac_seen, dac_pattern(v.exp_dac));
        check("audio_input", 64'(audio_input), 64'(v.exp_ain));
        check("sample_end_count", 64'(se_n), 64'd1);
        check("sample_end_pos", 64'(se_at), 64'd264);
        check("sample_req_count", 64'(sr_n), 64'd1);
        check("sample_req_pos", 64'(sr_at), 64'd1008);
        check("lrck_high_cycles", 64'(lr_hi), 64'd512);
        last_ain = v.exp_ain;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{aout: 16'hA5C3, adc: 16'h8001, exp_dac: 16'h0000, exp_ain: 16'h8001};
        vecs[1] = '{aout: 16'h1234, adc: 16'h5A5A, exp_dac: 16'hA5C3, exp_ain: 16'h5A5A};
        vecs[2] = '{aout: 16'hFFFF, adc: 16'h0000, exp_dac: 16'h1234, exp_ain: 16'h0000};
        vecs[3] = '{aout: 16'h0001, adc: 16'h7FFF, exp_dac: 16'hFFFF, exp_ain: 16'h7FFF};

        // Clock/reset
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_audio_input", 64'(audio_input), 64'd0);
        check("rst_bclk", 64'(aud_bclk), 64'd0);
        check("rst_lrck", 64'(aud_lrck), 64'd0);
        check("rst_dacdat", 64'(aud_dacdat), 64'd0);
        check("rst_sample_req", 64'(sample_req), 64'd0);
        check("rst_sample_end", 64'(sample_end), 64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        cyc      = 0;
        last_ain = 16'd0;

        for (int f = 0; f < 4; f++) begin
            run_frame(vecs[f]);
        end

`ifdef I2S_LOOPBACK_EN
        // Loopback: capture follows the DAC line, the ADC pin is ignored.
        loopback = 1'b1;
        vt = '{aout: 16'h7FFE, adc: 16'h0000, exp_dac: 16'h0001, exp_ain: 16'h0001};
        run_frame(vt);
        vt = '{aout: 16'h7FFE, adc: 16'h0000, exp_dac: 16'h7FFE, exp_ain: 16'h7FFE};
        run_frame(vt);
        loopback = 1'b0;
`endif

        // Mid-capture reset at bit_cnt = 9 while BCLK is high.
        aud_adcdat = 1'b1;
        repeat (156) step();
        check("pre_reset_bclk_high", 64'(aud_bclk), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_audio_input", 64'(audio_input), 64'd0);
        check("midrst_bclk", 64'(aud_bclk), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        cyc      = 0;
        last_ain = 16'd0;
        vt = '{aout: 16'h0000, adc: 16'hBEEF, exp_dac: 16'h0000, exp_ain: 16'hBEEF};
        run_frame(vt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
